motor_ramp_ctrl: RTL and testbench
==================================

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter CONFIRM_CYCLES, default 3: consecutive g-high samples required before ramping starts.
REQ-002 Parameter STEP_CYCLES, default 4: clock cycles between duty increments.
REQ-003 Parameter RAMP_STEP, default 16: duty increment per step.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port f  input  1  one-cycle start pulse from the upstream supervisory FSM.
REQ-007 Port g  input  1  motor-enable level from the upstream supervisory FSM.
REQ-008 Port duty  output  8  current PWM duty, 0..255.
REQ-009 Port pwm_out  output  1  PWM drive, high while pwm_cnt < duty.
REQ-010 Port running  output  1  high in RAMP or RUN.
REQ-011 Port ramp_done  output  1  high in RUN.
REQ-012 Port fault  output  1  high in FAULT.

Function
REQ-013 The FSM SHALL have states IDLE, ARMED, CONFIRM, RAMP, RUN, FAULT, and all status outputs SHALL be Moore, decoded from the registered state.
REQ-014 IDLE: f=1 -> ARMED; g is ignored in IDLE, including when f=1 and g=1 in the same cycle.
REQ-015 ARMED: g=1 -> CONFIRM with conf_cnt=1; otherwise remain in ARMED; f is ignored.
REQ-016 CONFIRM: g=1 with conf_cnt=CONFIRM_CYCLES-1 -> RAMP; g=1 otherwise -> conf_cnt+1; g=0 -> IDLE with no fault.
REQ-017 On entry to RAMP, duty=0 and step_cnt=0.
REQ-018 In RAMP, step_cnt SHALL count 0..STEP_CYCLES-1; on wrap, duty becomes min(duty+RAMP_STEP, 255), computed 9 bits wide, then saturated.
REQ-019 RAMP -> RUN on the same edge that duty saturates to 255.
REQ-020 With default parameters, duty SHALL go 0,16,...,240,255 and RAMP SHALL last 64 cycles.
REQ-021 RUN: duty holds at 255.
REQ-022 In RAMP or RUN, g=0 SHALL take priority over a step and go to FAULT, with duty forced to 0 on that edge.
REQ-023 FAULT SHALL be sticky until reset: duty=0, fault=1, and f and g are ignored.
REQ-024 In IDLE, ARMED and CONFIRM, duty SHALL be 0.
REQ-025 pwm_cnt SHALL be 8 bits, free-running and wrapping 255->0, so duty 255 gives 255 of every 256 cycles high and duty 0 gives constant low.
REQ-026 pwm_out SHALL be registered, reflecting duty and pwm_cnt from the previous cycle.

Reset
REQ-027 reset=1 at a clock edge SHALL override all inputs and any in-progress RAMP, RUN or FAULT.
REQ-028 Reset values: state=IDLE, duty=0, pwm_cnt=0, conf_cnt=0, step_cnt=0, pwm_out=0, running=0, ramp_done=0, fault=0.
REQ-029 After reset deasserts, the block SHALL require a fresh f pulse before it can leave IDLE.

Structure
REQ-030 Package motor_ctrl_pkg SHALL hold the state enum, the DUTY_MAX=255 constant and the parameter defaults.
REQ-031 Sub-module pwm_gen (inputs clk, reset, duty[7:0]; output pwm_out) SHALL own pwm_cnt and the compare register.
REQ-032 motor_ramp_ctrl SHALL instantiate pwm_gen exactly once.

Verification
REQ-033 Nominal: reset 2 cycles; f pulse; g high thereafter -> RAMP after the 3rd g-high sample, running=1, duty steps every 4 cycles, ramp_done=1 after 64 RAMP cycles with duty=255.
REQ-034 Upstream fail pattern: f pulse, then g high for exactly 2 cycles then low -> return to IDLE, fault=0, running never 1.
REQ-035 g drops in RAMP with duty=96 -> next edge state=FAULT, duty=0, fault=1; a later f and g=1 leave it in FAULT until reset.
REQ-036 f=1 and g=1 together in IDLE -> ARMED only, with conf_cnt reaching 1 on the following edge (g still 1).
REQ-037 Reset asserted in RUN -> next edge: all outputs 0, state=IDLE; pwm_out stays 0 for the following 256 cycles with no f pulse.
REQ-038 PWM check in RUN: pwm_out is high for 255 of every 256 consecutive cycles.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor ramp controller.
//   state_e            : controller FSM states
//   DUTY_MAX           : full-scale PWM duty
//   *_DEF              : default values for the controller parameters
//   sat_add_duty()     : 9-bit add of a duty and a step, saturated to DUTY_MAX
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_RAMP    = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam logic [7:0] DUTY_MAX = 8'd255;

  localparam int CONFIRM_CYCLES_DEF = 3;
  localparam int STEP_CYCLES_DEF    = 4;
  localparam int RAMP_STEP_DEF      = 16;

  // The sum is formed 9 bits wide so a carry out of bit 7 is seen as overflow.
  function automatic logic [7:0] sat_add_duty(input logic [7:0] duty,
                                              input logic [7:0] step);
    logic [8:0] sum;
    sum = {1'b0, duty} + {1'b0, step};
    if (sum >= {1'b0, DUTY_MAX}) return DUTY_MAX;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator with a free-running 8-bit counter.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   duty    : requested duty 0..255
//   pwm_out : registered drive, high when the previous cycle's counter was
//             below the previous cycle's duty
// The counter wraps 255 -> 0, so duty 255 is high 255 of every 256 cycles
// and duty 0 is constant low.
module pwm_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty,
  output logic       pwm_out
);

  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_out_q, pwm_out_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_out_d = (pwm_cnt_q < duty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= 8'd0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Motor soft-start controller.
// An f pulse arms the controller; g must then be high for CONFIRM_CYCLES
// consecutive samples before the duty ramps from 0 in RAMP_STEP increments
// every STEP_CYCLES cycles up to full scale (RUN). Losing g while ramping or
// running is a sticky FAULT that only reset clears.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   f         : one-cycle start pulse
//   g         : motor-enable level
//   duty      : current PWM duty (registered)
//   pwm_out   : registered PWM drive
//   running   : high in RAMP or RUN
//   ramp_done : high in RUN
//   fault     : high in FAULT
//   state_dbg : current FSM state
// CONFIRM_CYCLES must be at least 2 (ARMED consumes the first g sample).
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int CONFIRM_CYCLES = CONFIRM_CYCLES_DEF,
  parameter int STEP_CYCLES    = STEP_CYCLES_DEF,
  parameter int RAMP_STEP      = RAMP_STEP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f,
  input  logic       g,
  output logic [7:0] duty,
  output logic       pwm_out,
  output logic       running,
  output logic       ramp_done,
  output logic       fault,
  output state_e     state_dbg
);

  localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int STEP_W = $clog2(STEP_CYCLES + 1);

  state_e            state_q, state_d;
  logic [7:0]        duty_q, duty_d;
  logic [CONF_W-1:0] conf_cnt_q, conf_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [7:0]        next_duty;

  assign next_duty = sat_add_duty(duty_q, 8'(RAMP_STEP));

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    conf_cnt_d = conf_cnt_q;
    step_cnt_d = step_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        duty_d     = 8'd0;
        conf_cnt_d = '0;
        step_cnt_d = '0;
        if (f) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        duty_d = 8'd0;
        if (g) begin
          state_d    = ST_CONFIRM;
          conf_cnt_d = CONF_W'(1);
        end
      end
      ST_CONFIRM: begin
        duty_d = 8'd0;
        if (!g) begin
          state_d    = ST_IDLE;
          conf_cnt_d = '0;
        end else if (conf_cnt_q == CONF_W'(CONFIRM_CYCLES - 1)) begin
          state_d    = ST_RAMP;
          conf_cnt_d = '0;
          step_cnt_d = '0;
        end else begin
          conf_cnt_d = conf_cnt_q + CONF_W'(1);
        end
      end
      ST_RAMP: begin
        // Loss of g wins over a step landing on the same edge.
        if (!g) begin
          state_d    = ST_FAULT;
          duty_d     = 8'd0;
          step_cnt_d = '0;
        end else if (step_cnt_q == STEP_W'(STEP_CYCLES - 1)) begin
          step_cnt_d = '0;
          duty_d     = next_duty;
          if (next_duty == DUTY_MAX) state_d = ST_RUN;
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      ST_RUN: begin
        duty_d = DUTY_MAX;
        if (!g) begin
          state_d = ST_FAULT;
          duty_d  = 8'd0;
        end
      end
      ST_FAULT: begin
        duty_d = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      duty_q     <= 8'd0;
      conf_cnt_q <= '0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      conf_cnt_q <= conf_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign duty      = duty_q;
  assign running   = (state_q == ST_RAMP) || (state_q == ST_RUN);
  assign ramp_done = (state_q == ST_RUN);
  assign fault     = (state_q == ST_FAULT);
  assign state_dbg = state_q;

  pwm_gen u_pwm_gen (
    .clk     (clk),
    .reset   (reset),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl. Each driven cycle feeds a behavioural model that
// tracks the controller as "armed / consecutive g highs / ramp age / faulted"
// and derives duty arithmetically from the ramp age. Expected outputs are
// queued; a monitor on the falling edge pops one entry per cycle and compares.
module tb_motor_ramp_ctrl;
  import motor_ctrl_pkg::*;

  localparam int CONF = 3;
  localparam int STEP = 4;
  localparam int RSTEP = 16;

  typedef struct packed {
    logic [7:0] duty;
    logic       pwm;
    logic       running;
    logic       done;
    logic       fault;
    logic [2:0] st;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic f = 1'b0;
  logic g = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] duty;
  logic       pwm_out, running, ramp_done, fault;
  state_e     state_dbg;

  motor_ramp_ctrl #(
    .CONFIRM_CYCLES (CONF),
    .STEP_CYCLES    (STEP),
    .RAMP_STEP      (RSTEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .f         (f),
    .g         (g),
    .duty      (duty),
    .pwm_out   (pwm_out),
    .running   (running),
    .ramp_done (ramp_done),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  bit m_armed;
  int m_g_run;     // consecutive g-high samples since arming
  int m_ramp_age;  // edges since ramp entry, -1 when not ramping/running
  bit m_faulted;
  int m_pwm_phase; // counter value the PWM generator holds
  int m_duty;      // duty expected after the last edge
  exp_t exp_q[$];

  function automatic int ramp_raw(input int age);
    return RSTEP * (age / STEP);
  endfunction

  task automatic model_step(input logic rst_i, input logic f_i, input logic g_i);
    exp_t e;
    logic exp_pwm;
    if (rst_i) begin
      m_armed = 0; m_g_run = 0; m_ramp_age = -1; m_faulted = 0;
      m_pwm_phase = 0; exp_pwm = 1'b0;
    end else begin
      exp_pwm = (m_pwm_phase < m_duty);
      m_pwm_phase = (m_pwm_phase + 1) % 256;
      if (m_faulted) begin
        // sticky
      end else if (m_ramp_age >= 0) begin
        if (!g_i) begin
          m_faulted = 1; m_ramp_age = -1;
        end else begin
          m_ramp_age++;
        end
      end else if (m_armed) begin
        if (g_i) begin
          m_g_run++;
          if (m_g_run == CONF) begin
            m_armed = 0; m_g_run = 0; m_ramp_age = 0;
          end
        end else if (m_g_run > 0) begin
          m_armed = 0; m_g_run = 0;
        end
      end else if (f_i) begin
        m_armed = 1;
      end
    end
    if (m_ramp_age >= 0) m_duty = (ramp_raw(m_ramp_age) >= 255) ? 255 : ramp_raw(m_ramp_age);
    else m_duty = 0;
    e.duty    = 8'(m_duty);
    e.pwm     = exp_pwm;
    e.running = (m_ramp_age >= 0);
    e.done    = (m_ramp_age >= 0) && (ramp_raw(m_ramp_age) >= 255);
    e.fault   = m_faulted;
    if (m_faulted)                   e.st = ST_FAULT;
    else if (e.done)                 e.st = ST_RUN;
    else if (m_ramp_age >= 0)        e.st = ST_RAMP;
    else if (m_armed && m_g_run > 0) e.st = ST_CONFIRM;
    else if (m_armed)                e.st = ST_ARMED;
    else                             e.st = ST_IDLE;
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst_i, input logic f_i, input logic g_i);
    reset = rst_i; f = f_i; g = g_i;
    model_step(rst_i, f_i, g_i);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input int n, input logic f_i, input logic g_i);
    for (int i = 0; i < n; i++) drive(1'b0, f_i, g_i);
  endtask

  // ---------------- scoreboard / monitor ----------------
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("duty",      duty,                    e.duty);
      check("pwm_out",   {7'd0, pwm_out},         {7'd0, e.pwm});
      check("running",   {7'd0, running},         {7'd0, e.running});
      check("ramp_done", {7'd0, ramp_done},       {7'd0, e.done});
      check("fault",     {7'd0, fault},           {7'd0, e.fault});
      check("state",     {5'd0, 3'(state_dbg)},   {5'd0, e.st});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic gl;
    #1;
    // reset for 2 cycles
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);

    // nominal start: f pulse, then g high through ramp and a long RUN stretch
    drive_n(2, 1'b0, 1'b0);
    drive_n(1, 1'b1, 1'b0);
    drive_n(3 + 64 + 600, 1'b0, 1'b1);

    // reset while running, then idle with g wandering and no f
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));

    // upstream fail pattern: g high only two samples
    drive_n(1, 1'b1, 1'b0);
    drive_n(2, 1'b0, 1'b1);
    drive_n(10, 1'b0, 1'b0);

    // f and g together in IDLE, then g held; drop g once duty reaches 96
    drive_n(1, 1'b1, 1'b1);
    drive_n(3 + 24, 1'b0, 1'b1);
    drive_n(1, 1'b0, 1'b0);
    // FAULT must ignore a fresh start attempt
    drive_n(1, 1'b1, 1'b1);
    drive_n(20, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive_n(5, 1'b0, 1'b1);

    // random segments of held g with sparse f pulses and rare resets
    for (int s = 0; s < 60; s++) begin
      len = $urandom_range(1, 90);
      gl  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++)
        drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) == 0), gl);
    end

    // let the monitor drain, bounded
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
